stage_3_ex: RTL and testbench
=============================

// Module: stage_3_ex
// PURPOSE
//  Execute stage of the 5-stage LoongArch pipeline. Sits between ID (stage 2) and the
//  memory-access stage (stage 4).
//  - Latches the ID->EX bus and the store data.
//  - Computes the 12-op ALU result.
//  - Issues the data-SRAM request for ld.w/st.w.
//  - Exports its destination register to ID for hazard detection.
//  - Passes {rf_we,dest,res_from_mem,alu_result,pc} downstream under a valid/allow handshake.
// PARAMETERS
//  IN_W   117  width of stage_2_to_3 bus
//  OUT_W   71  width of stage_3_to_4 bus
// PORTS
//  clk                input   1      clock, all state on posedge
//  reset              input   1      synchronous, active-high reset
//  valid_2            input   1      ID holds a valid instruction
//  allow_3            output  1      EX can accept a new instruction this cycle
//  valid_3            output  1      EX holds a valid instruction
//  allow_4            input   1      stage 4 can accept this cycle
//  stage_2_to_3       input   117    {rf_we[116],dest[115:111],res_from_mem[110],src1[109:78],
//                                     src2[77:46],alu_op[45:34],mem_we[33],mem_en[32],pc[31:0]}
//  memory_write_data  input   32     store data (rkd_value) from ID
//  stage_3_to_4       output  71     {rf_we,dest[4:0],res_from_mem,alu_result[31:0],pc[31:0]}
//  data_sram_en       output  1      data-SRAM access enable
//  data_sram_we       output  4      byte write enables
//  data_sram_addr     output  32     byte address = alu_result
//  data_sram_wdata    output  32     latched store data
//  rf_waddr_3_fwd     output  5      EX destination register, 0 when no GPR write pending
// BEHAVIOUR
//  Handshake:
//  - readygo_3 = 1; the ALU is single-cycle.
//  - allow_3 = ~valid_3_r | allow_4.
//  - On posedge when allow_3=1: valid_3_r <= valid_2.
//  - When valid_2 & allow_3, the bus and memory_write_data are also latched.
//  - When allow_3=0, all latched state holds.
//  Outputs:
//  - valid_3 = valid_3_r.
//  - All outputs are combinational from latched state; latency is 1 cycle from ID.
//  Reset:
//  - valid_3_r=0 and all latched fields are 0.
//  - Consequently valid_3=0, allow_3=1, stage_3_to_4=0, data_sram_en=0, data_sram_we=0,
//    rf_waddr_3_fwd=0.
//  - Reset mid-operation discards the held instruction; it is never issued.
//  ALU:
//  - alu_op is one-hot. [0] add, [1] sub, [2] slt (signed), [3] sltu, [4] and, [5] nor,
//    [6] or, [7] xor.
//  - [8] sll src1<<src2[4:0], [9] srl logical, [10] sra arithmetic, [11] lui: result=src2.
//  - All arithmetic is 32-bit with wrap-around and no overflow trap.
//  - slt/sltu produce 0 or 1.
//  - Shift amount uses only src2[4:0].
//  - alu_op=0 gives result 0.
//  Memory:
//  - data_sram_en = valid_3_r & mem_en & allow_4.
//  - The request fires only in the cycle the instruction advances, so a stall never issues
//    a duplicate.
//  - data_sram_we = {4{mem_we & data_sram_en}}.
//  - data_sram_addr = alu_result; data_sram_wdata = latched store data.
//  - ld.w read data returns the next cycle to stage 4.
//  Forwarding:
//  - rf_waddr_3_fwd = (valid_3_r & rf_we) ? dest : 5'd0. Dest r0 naturally reads as 0.
//  - ID treats a nonzero value as a pending write.
//  Simultaneous events:
//  - Stall (allow_4=0) while valid_2=1: EX holds its instruction and allow_3=0.
//  - With valid_3_r=0, allow_3=1 regardless of allow_4.
//  - If ID branch-flush deasserts valid_2, EX latches valid_3_r=0 (bubble).
// TESTING
//  1. Reset held 2 cycles, then released -> valid_3=0, allow_3=1, data_sram_en=0, rf_waddr_3_fwd=0.
//  2. add src1=0x7FFFFFFF, src2=1, dest=5, rf_we=1 -> next cycle alu_result=0x80000000, rf_waddr_3_fwd=5.
//  3. slt src1=0xFFFFFFFF, src2=1 -> result 1; sltu with the same operands -> 0;
//     sra src1=0x80000000, src2=0x24 -> 0xF8000000.
//  4. st.w src1=0x1000, src2=8, wdata=0xDEADBEEF, allow_4=1 -> data_sram_en=1, we=4'hF,
//     addr=0x1008, wdata=0xDEADBEEF, for exactly 1 cycle.
//  5. ld.w with allow_4=0 for 3 cycles -> data_sram_en=0, allow_3=0, bus held stable;
//     on the allow_4=1 cycle en=1 once, we=0.
//  6. Reset asserted while a valid st.w is held and stalled -> next cycle valid_3=0;
//     no SRAM write ever issued for it.

Source files
------------

// File: rtl/stage_3_ex.sv
// Execute stage of the 5-stage LoongArch pipeline: latches the ID->EX bus, runs the
// single-cycle ALU, issues data-SRAM requests and exports the pending destination register.
module stage_3_ex #(
   parameter int IN_W  = 117,
   parameter int OUT_W = 71
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_2,
   output logic              allow_3,
   output logic              valid_3,
   input  logic              allow_4,
   input  logic [IN_W-1:0]   stage_2_to_3,
   input  logic [31:0]       memory_write_data,
   output logic [OUT_W-1:0]  stage_3_to_4,
   output logic              data_sram_en,
   output logic [3:0]        data_sram_we,
   output logic [31:0]       data_sram_addr,
   output logic [31:0]       data_sram_wdata,
   output logic [4:0]        rf_waddr_3_fwd
);

   logic              r_valid_3;
   logic [IN_W-1:0]   r_bus;
   logic [31:0]       r_wdata;

   logic              w_rf_we;
   logic [4:0]        w_dest;
   logic              w_res_from_mem;
   logic [31:0]       w_src1;
   logic [31:0]       w_src2;
   logic [11:0]       w_alu_op;
   logic              w_mem_we;
   logic              w_mem_en;
   logic [31:0]       w_pc;
   logic [4:0]        w_shamt;
   logic [31:0]       w_add;
   logic [31:0]       w_sub;
   logic [31:0]       w_slt;
   logic [31:0]       w_sltu;
   logic [31:0]       w_sll;
   logic [31:0]       w_srl;
   logic [31:0]       w_sra;
   logic [31:0]       w_alu_result;

   // readygo is always 1, so EX frees up whenever stage 4 accepts.
   assign allow_3 = ~r_valid_3 | allow_4;
   assign valid_3 = r_valid_3;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_3 <= 1'b0;
         r_bus     <= '0;
         r_wdata   <= '0;
      end else if (allow_3) begin
         r_valid_3 <= valid_2;
         if (valid_2) begin
            r_bus   <= stage_2_to_3;
            r_wdata <= memory_write_data;
         end
      end
   end

   assign w_rf_we        = r_bus[116];
   assign w_dest         = r_bus[115:111];
   assign w_res_from_mem = r_bus[110];
   assign w_src1         = r_bus[109:78];
   assign w_src2         = r_bus[77:46];
   assign w_alu_op       = r_bus[45:34];
   assign w_mem_we       = r_bus[33];
   assign w_mem_en       = r_bus[32];
   assign w_pc           = r_bus[31:0];

   assign w_shamt = w_src2[4:0];
   assign w_add   = w_src1 + w_src2;
   assign w_sub   = w_src1 - w_src2;
   assign w_slt   = {31'd0, $signed(w_src1) < $signed(w_src2)};
   assign w_sltu  = {31'd0, w_src1 < w_src2};
   assign w_sll   = w_src1 << w_shamt;
   assign w_srl   = w_src1 >> w_shamt;
   assign w_sra   = $unsigned($signed(w_src1) >>> w_shamt);

   // One-hot AND-OR select; an all-zero opcode naturally yields 0.
   always_comb begin
      w_alu_result = ({32{w_alu_op[0]}}  & w_add)
                   | ({32{w_alu_op[1]}}  & w_sub)
                   | ({32{w_alu_op[2]}}  & w_slt)
                   | ({32{w_alu_op[3]}}  & w_sltu)
                   | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
                   | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                   | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
                   | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                   | ({32{w_alu_op[8]}}  & w_sll)
                   | ({32{w_alu_op[9]}}  & w_srl)
                   | ({32{w_alu_op[10]}} & w_sra)
                   | ({32{w_alu_op[11]}} & w_src2);
   end

   assign stage_3_to_4 = {w_rf_we, w_dest, w_res_from_mem, w_alu_result, w_pc};

   // Request only in the cycle the instruction advances, so a stall never repeats it.
   assign data_sram_en    = r_valid_3 & w_mem_en & allow_4;
   assign data_sram_we    = {4{w_mem_we & data_sram_en}};
   assign data_sram_addr  = w_alu_result;
   assign data_sram_wdata = r_wdata;

   assign rf_waddr_3_fwd = (r_valid_3 & w_rf_we) ? w_dest : 5'd0;

endmodule

// File: tb/tb_stage_3_ex.sv
// Bench for stage_3_ex: a cycle-level instruction-holding model with an arithmetic ALU
// reference, checked every cycle, plus directed scenarios with literal expectations.
module tb_stage_3_ex;

   localparam logic [11:0] OP_ADD  = 12'h001;
   localparam logic [11:0] OP_SLT  = 12'h004;
   localparam logic [11:0] OP_SLTU = 12'h008;
   localparam logic [11:0] OP_OR   = 12'h040;
   localparam logic [11:0] OP_SRA  = 12'h400;

   logic          clk;
   logic          reset;
   logic          valid_2;
   logic          allow_3;
   logic          valid_3;
   logic          allow_4;
   logic [116:0]  stage_2_to_3;
   logic [31:0]   memory_write_data;
   logic [70:0]   stage_3_to_4;
   logic          data_sram_en;
   logic [3:0]    data_sram_we;
   logic [31:0]   data_sram_addr;
   logic [31:0]   data_sram_wdata;
   logic [4:0]    rf_waddr_3_fwd;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_2000_cnt = 0;
   bit checking = 0;

   stage_3_ex dut (
      .clk               (clk),
      .reset             (reset),
      .valid_2           (valid_2),
      .allow_3           (allow_3),
      .valid_3           (valid_3),
      .allow_4           (allow_4),
      .stage_2_to_3      (stage_2_to_3),
      .memory_write_data (memory_write_data),
      .stage_3_to_4      (stage_3_to_4),
      .data_sram_en      (data_sram_en),
      .data_sram_we      (data_sram_we),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .rf_waddr_3_fwd    (rf_waddr_3_fwd)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [116:0] pack(input logic rf_we, input logic [4:0] dest,
                                         input logic rfm, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [11:0] op,
                                         input logic mwe, input logic men,
                                         input logic [31:0] pc);
      return {rf_we, dest, rfm, s1, s2, op, mwe, men, pc};
   endfunction

   function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         12'h001: return a + b;
         12'h002: return a - b;
         12'h004: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         12'h008: return (a < b) ? 32'd1 : 32'd0;
         12'h010: return a & b;
         12'h020: return ~(a | b);
         12'h040: return a | b;
         12'h080: return a ^ b;
         12'h100: return a << sh;
         12'h200: return a >> sh;
         12'h400: return a[31] ? ~((~a) >> sh) : (a >> sh);
         12'h800: return b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: what instruction EX holds and with which store data.
   bit           m_valid;
   logic [116:0] m_bus;
   logic [31:0]  m_wdata;

   always @(posedge clk) begin
      if (reset) begin
         m_valid = 0;
         m_bus   = '0;
         m_wdata = '0;
      end else if (!m_valid || allow_4) begin
         m_valid = valid_2;
         if (valid_2) begin
            m_bus   = stage_2_to_3;
            m_wdata = memory_write_data;
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] res;
      logic        en;
      if (checking) begin
         res = alu_ref(m_bus[45:34], m_bus[109:78], m_bus[77:46]);
         en  = m_valid && m_bus[32] && allow_4;
         check("valid_3", valid_3, m_valid);
         check("allow_3", allow_3, !m_valid || allow_4);
         check("stage_3_to_4", stage_3_to_4, {m_bus[116], m_bus[115:111], m_bus[110], res, m_bus[31:0]});
         check("sram_en", data_sram_en, en);
         check("sram_we", data_sram_we, (en && m_bus[33]) ? 4'hF : 4'h0);
         check("sram_addr", data_sram_addr, res);
         check("sram_wdata", data_sram_wdata, m_wdata);
         check("fwd", rf_waddr_3_fwd, (m_valid && m_bus[116]) ? m_bus[115:111] : 5'd0);
      end
      if (data_sram_en && data_sram_we != 4'h0 && data_sram_addr == 32'h2000)
         wr_2000_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [116:0] bus, input logic [31:0] wd);
      valid_2           = v;
      stage_2_to_3      = bus;
      memory_write_data = wd;
   endtask

   initial begin
      logic [70:0]  held;
      logic [31:0]  ops_a [4];
      logic [31:0]  ops_b [4];
      logic [11:0]  op;
      ops_a = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
      ops_b = '{32'h0000_0001, 32'h0000_0024, 32'hF0F0_00FF, 32'h0000_001F};

      reset = 1; allow_4 = 1;
      drive(0, '0, '0);
      step();
      checking = 1;
      step();
      reset = 0;
      step();
      // Test 1: post-reset state
      check("t1_valid_3", valid_3, 1'b0);
      check("t1_allow_3", allow_3, 1'b1);
      check("t1_sram_en", data_sram_en, 1'b0);
      check("t1_fwd", rf_waddr_3_fwd, 5'd0);
      check("t1_bus", stage_3_to_4, 71'd0);

      // Model self-pins
      check("ref_sra", alu_ref(OP_SRA, 32'h8000_0000, 32'h24), 32'hF800_0000);
      check("ref_slt", alu_ref(OP_SLT, 32'hFFFF_FFFF, 32'h1), 32'd1);

      // Test 2: add wraps, forwarding dest
      drive(1, pack(1, 5'd5, 0, 32'h7FFF_FFFF, 32'h1, OP_ADD, 0, 0, 32'h1C00_0000), '0);
      step();
      check("t2_result", stage_3_to_4[63:32], 32'h8000_0000);
      check("t2_fwd", rf_waddr_3_fwd, 5'd5);

      // Test 3: slt / sltu / sra
      drive(1, pack(1, 5'd6, 0, 32'hFFFF_FFFF, 32'h1, OP_SLT, 0, 0, 32'h1C00_0004), '0);
      step();
      check("t3_slt", stage_3_to_4[63:32], 32'd1);
      drive(1, pack(1, 5'd7, 0, 32'hFFFF_FFFF, 32'h1, OP_SLTU, 0, 0, 32'h1C00_0008), '0);
      step();
      check("t3_sltu", stage_3_to_4[63:32], 32'd0);
      drive(1, pack(1, 5'd8, 0, 32'h8000_0000, 32'h24, OP_SRA, 0, 0, 32'h1C00_000C), '0);
      step();
      check("t3_sra", stage_3_to_4[63:32], 32'hF800_0000);
      drive(1, pack(1, 5'd0, 0, 32'h1, 32'h1, OP_ADD, 0, 0, 32'h1C00_0010), '0);
      step();
      check("t3_fwd_r0", rf_waddr_3_fwd, 5'd0);

      // Test 4: st.w issues exactly one write
      drive(1, pack(0, 5'd0, 0, 32'h1000, 32'h8, OP_ADD, 1, 1, 32'h1C00_0014), 32'hDEAD_BEEF);
      step();
      check("t4_en", data_sram_en, 1'b1);
      check("t4_we", data_sram_we, 4'hF);
      check("t4_addr", data_sram_addr, 32'h1008);
      check("t4_wdata", data_sram_wdata, 32'hDEAD_BEEF);
      valid_2 = 0;
      step();
      check("t4_en_off", data_sram_en, 1'b0);
      check("t4_valid_off", valid_3, 1'b0);

      // Test 5: ld.w stalled 3 cycles with ID holding another instruction
      allow_4 = 0;
      drive(1, pack(1, 5'd9, 1, 32'h3000, 32'h4, OP_ADD, 0, 1, 32'h1C00_0018), 32'h5555_AAAA);
      step();
      check("t5_en_stall", data_sram_en, 1'b0);
      check("t5_allow_stall", allow_3, 1'b0);
      held = stage_3_to_4;
      drive(1, pack(1, 5'd10, 0, 32'h0F0F_0000, 32'h00F0, OP_OR, 0, 0, 32'h1C00_001C), '0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("t5_en_stall", data_sram_en, 1'b0);
         check("t5_allow_stall", allow_3, 1'b0);
         check("t5_bus_held", stage_3_to_4, held);
      end
      allow_4 = 1;
      #1;
      check("t5_en_go", data_sram_en, 1'b1);
      check("t5_we_go", data_sram_we, 4'h0);
      check("t5_addr_go", data_sram_addr, 32'h3004);
      step();
      check("t5_next_pc", stage_3_to_4[31:0], 32'h1C00_001C);
      check("t5_next_res", stage_3_to_4[63:32], 32'h0F0F_00F0);
      valid_2 = 0;
      step();

      // Test 6: reset discards a stalled st.w
      allow_4 = 0;
      drive(1, pack(0, 5'd0, 0, 32'h2000, 32'h0, OP_ADD, 1, 1, 32'h1C00_0020), 32'hCAFE_F00D);
      step();
      check("t6_valid_held", valid_3, 1'b1);
      check("t6_en_stall", data_sram_en, 1'b0);
      valid_2 = 0;
      step();
      reset = 1;
      step();
      check("t6_valid_rst", valid_3, 1'b0);
      check("t6_allow_rst", allow_3, 1'b1);
      reset = 0;
      allow_4 = 1;
      step();
      step();
      check("t6_no_write", wr_2000_cnt, 0);

      // ALU sweep across every opcode with mixed stalls and bubbles
      for (int k = 0; k < 13; k++) begin
         for (int j = 0; j < 4; j++) begin
            op = (k == 12) ? 12'h000 : (12'h001 << k);
            allow_4 = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 4) != 0),
                  pack(j[0], 5'(k + j), 0, ops_a[j], ops_b[j], op, j[1], j[0], 32'h1C00_1000 + 32'(4 * k)),
                  32'h0100_0000 + 32'(j));
            step();
         end
      end
      allow_4 = 1;
      drive(1, pack(1, 5'd3, 0, 32'h0, 32'hABCD_0000, 12'h800, 0, 0, 32'h1C00_2000), '0);
      step();
      check("sw_lui", stage_3_to_4[63:32], 32'hABCD_0000);
      valid_2 = 0;
      step();
      check("sw_bubble", valid_3, 1'b0);
      step();

      checking = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
